adex_param_loader_tx: RTL and testbench
=======================================

Name: adex_param_loader_tx

Overview:
Host-side transmitter for the AdEx neuron nibble-serial parameter-load protocol. It snapshots eight 8-bit parameters and drives load_mode, load_enable and a 4-bit nibble bus with the exact strobe sequence the neuron's loader expects:
- one start strobe;
- 16 data nibbles, high nibble first, ordered DeltaT, TauW, a, b, Vreset, VT, Ibias, C;
- footer nibble 4'hF.

It then holds load_mode high until released. It sits in the test harness / companion controller driving ui_in[4:3] and uio_in[3:0].

Parameters:
- STROBE_HIGH, 2, cycles load_enable stays high per strobe (>=1).
- STROBE_LOW, 2, cycles load_enable stays low between strobes, and ARM length (>=1).
- STROBE_HIGH+STROBE_LOW must be >=3; elaboration error otherwise. This covers the receiver's latch cycle.
- AUTO_RELEASE_CYCLES, 4, HOLD length before auto-release (used only with the macro).

Ports:
- clk, in, 1, clock
- reset, in, 1, reset, synchronous, active-high
- start, in, 1, pulse; begin a load (accepted only in IDLE)
- params, in, 64, [63:56]=DeltaT, [55:48]=TauW, [47:40]=a, [39:32]=b, [31:24]=Vreset, [23:16]=VT, [15:8]=Ibias, [7:0]=C
- release, in, 1, end HOLD and drop load_mode (honoured only in HOLD)
- abort, in, 1, terminate any in-progress load
- load_mode, out, 1, to receiver load_mode
- load_enable, out, 1, to receiver load_enable (strobe)
- nibble, out, 4, to receiver nibble bus
- busy, out, 1, high in every state except IDLE
- holding, out, 1, high in HOLD (receiver has committed params)
- done, out, 1, one-cycle pulse on first HOLD cycle

Behaviour:
- All outputs are registered. Reset value of every output is 0; state goes to IDLE, counters clear, snapshot clears. Reset mid-load drops load_mode next edge, so the receiver returns to idle.
- States: IDLE, ARM, STRB_HI, STRB_LO, HOLD, RELEASE.
- IDLE:
  - start=1 at edge E: snapshot params, strobe index k=0, go to ARM.
  - load_mode=1 from E+1.
- ARM:
  - load_mode=1, load_enable=0, nibble=0, for STROBE_LOW cycles.
  - Then go to STRB_HI.
- Strobe k, k=0..17:
  - Nibble values: k=0 is 4'h0 (start strobe, content ignored); k=1..16 is snapshot nibble k-1, MSB-first; k=17 is 4'hF.
  - STRB_HI drives load_enable=1 for STROBE_HIGH cycles.
  - STRB_LO drives load_enable=0 for STROBE_LOW cycles.
  - After the low phase: increment k, or go to HOLD when k=17.
  - nibble is updated on entry to STRB_LO of the previous strobe (or in ARM) and never changes while load_enable=1.
- Timing with defaults: start sampled at cycle 0. Strobe k is high at cycles 3+4k and 4+4k. HOLD is entered at cycle 75 with done=1.
- HOLD: load_mode=1, holding=1. release=1 goes to RELEASE.
- RELEASE:
  - load_mode=0 for exactly 1 cycle, then IDLE.
  - This guarantees the receiver sees load_mode low and clears its ready.
- start is ignored unless in IDLE; it is not queued.
- start and release asserted in the same cycle: release wins if in HOLD; start is ignored.
- abort, any state except IDLE: next cycle load_mode=0 and load_enable=0, go to IDLE. No done pulse. abort has priority over release.
- Strobe spacing is fixed and far below the receiver watchdog of 50000 cycles.

Optional Feature:
- Macro: ADEX_TX_AUTO_RELEASE_EN.
- Defined: HOLD counts AUTO_RELEASE_CYCLES cycles, then enters RELEASE automatically. release still exits early.
- Undefined: HOLD persists until release or abort. AUTO_RELEASE_CYCLES is unused.

Decomposition:
- Package adex_loader_pkg holds:
  - FOOTER_NIB=4'hF;
  - NUM_PARAMS=8;
  - NUM_STROBES=18;
  - parameter byte-index constants (IDX_DELTAT..IDX_C);
  - the state enum.
- The receiver side imports the same constants.
- One sub-module is natural: adex_strobe_gen, a phase counter producing hi/lo phase timing and a phase_done tick. The FSM plus nibble mux stay in the top.

Test Plan:
- Nominal load, defaults. params = 82_64_02_28_3F_4E_90_C8, start pulse → 18 rising edges of load_enable carrying nibbles 0,8,2,6,4,0,2,2,8,3,F,4,E,9,0,C,8,F. done at cycle 75. Paired receiver r_ready=1 with matching bytes.
- Nibble stability. Monitor → nibble never changes while load_enable=1. Each high pulse lasts 2 cycles; each low gap lasts 2 cycles.
- Release handshake. release in HOLD → load_mode=0 for exactly 1 cycle, then IDLE. Receiver ready clears. Back-to-back start succeeds the cycle after.
- Abort mid-load. abort after strobe 5 → load_mode and load_enable are 0 next cycle, no done pulse. Receiver returns to idle with r_* unchanged.
- Ignored stimuli:
  - start during busy → no effect;
  - params changed after start → transmitted bytes equal the snapshot;
  - release in IDLE → no effect.
- Macro and reset. With ADEX_TX_AUTO_RELEASE_EN: RELEASE is entered 4 cycles after done. Reset asserted mid-strobe → all outputs 0 next cycle.

Source files
------------

// File: rtl/adex_loader_pkg.sv
// rtl/adex_loader_pkg.sv - shared constants, state enum and nibble select for the AdEx parameter-load protocol
package adex_loader_pkg;

  localparam logic [3:0] FOOTER_NIB  = 4'hF;
  localparam int         NUM_PARAMS  = 8;
  localparam int         NUM_STROBES = 2 * NUM_PARAMS + 2;

  // Byte index within the 64-bit parameter word ([8*i+7:8*i])
  localparam int IDX_DELTAT = 7;
  localparam int IDX_TAUW   = 6;
  localparam int IDX_A      = 5;
  localparam int IDX_B      = 4;
  localparam int IDX_VRESET = 3;
  localparam int IDX_VT     = 2;
  localparam int IDX_IBIAS  = 1;
  localparam int IDX_C      = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_STRB_HI = 3'd2,
    ST_STRB_LO = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RELEASE = 3'd5
  } tx_state_t;

  // Strobe 0 is the start strobe, 1..16 carry the snapshot MSB-first, the last is the footer
  function automatic logic [3:0] strobe_nibble(input logic [63:0] snap, input logic [4:0] k);
    logic [63:0] shifted;
    logic [5:0]  sh_amt;
    logic [3:0]  nib;
    nib     = 4'h0;
    sh_amt  = {k[3:0] - 4'd1, 2'b00};
    shifted = snap << sh_amt;
    if (k == 5'(NUM_STROBES - 1))
      nib = FOOTER_NIB;
    else if (k != 5'd0)
      nib = shifted[63:60];
    return nib;
  endfunction

endpackage

// File: rtl/adex_param_loader_tx_if.sv
// rtl/adex_param_loader_tx_if.sv - receiver-facing load bus (load_mode, load_enable, nibble)
interface adex_param_loader_tx_if;
  logic       load_mode;
  logic       load_enable;
  logic [3:0] nibble;

  modport master (output load_mode, output load_enable, output nibble);
  modport slave  (input  load_mode, input  load_enable, input  nibble);
endinterface

// File: rtl/adex_param_loader_tx_strobe_gen.sv
// rtl/adex_param_loader_tx_strobe_gen.sv - phase counter timing the high/low halves of each strobe
module adex_strobe_gen #(
  parameter int STROBE_HIGH = 2,
  parameter int STROBE_LOW  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic hi,
  output logic phase_done
);

  localparam int MAX_LEN = (STROBE_HIGH > STROBE_LOW) ? STROBE_HIGH : STROBE_LOW;
  localparam int CW      = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;

  assign last       = hi ? CW'(STROBE_HIGH - 1) : CW'(STROBE_LOW - 1);
  assign phase_done = run && (cnt == last);

  // Counter restarts at every phase boundary and rests at zero while idle
  always_ff @(posedge clk) begin
    if (reset || !run || phase_done)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/adex_param_loader_tx.sv
// rtl/adex_param_loader_tx.sv - nibble-serial AdEx parameter-load transmitter
// Optional ADEX_TX_AUTO_RELEASE_EN: HOLD exits by itself after AUTO_RELEASE_CYCLES.
module adex_param_loader_tx
  import adex_loader_pkg::*;
#(
  parameter int STROBE_HIGH         = 2,
  parameter int STROBE_LOW          = 2,
  parameter int AUTO_RELEASE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [63:0]                   params,
  input  logic                          release_req,
  input  logic                          abort,
  adex_param_loader_tx_if.master        bus,
  output logic                          busy,
  output logic                          holding,
  output logic                          done
);

  localparam logic [4:0] LAST_K = 5'(NUM_STROBES - 1);

  if (STROBE_HIGH < 1 || STROBE_LOW < 1 || STROBE_HIGH + STROBE_LOW < 3) begin : g_bad_timing
    $error("adex_param_loader_tx: strobe timing too short for the receiver latch");
  end
  if (AUTO_RELEASE_CYCLES < 1) begin : g_bad_auto
    $error("adex_param_loader_tx: AUTO_RELEASE_CYCLES must be >= 1");
  end

  tx_state_t   state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic [63:0] snap_q, snap_d;
  logic [3:0]  nib_q, nib_d;
  logic        load_mode_q, load_enable_q;
  logic        phase_done;

  adex_strobe_gen #(
    .STROBE_HIGH (STROBE_HIGH),
    .STROBE_LOW  (STROBE_LOW)
  ) u_strobe_gen (
    .clk        (clk),
    .reset      (reset),
    .run        (state_q == ST_ARM || state_q == ST_STRB_HI || state_q == ST_STRB_LO),
    .hi         (state_q == ST_STRB_HI),
    .phase_done (phase_done)
  );

`ifdef ADEX_TX_AUTO_RELEASE_EN
  logic [15:0] hold_cnt;
  always_ff @(posedge clk) begin
    if (reset || state_q != ST_HOLD)
      hold_cnt <= '0;
    else
      hold_cnt <= hold_cnt + 16'd1;
  end
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    snap_d  = snap_q;
    nib_d   = nib_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          k_d     = 5'd0;
          snap_d  = params;
          nib_d   = 4'h0;
        end
      end
      ST_ARM: begin
        if (phase_done) state_d = ST_STRB_HI;
      end
      ST_STRB_HI: begin
        // Next strobe's nibble is set up here so it is stable long before its rising edge
        if (phase_done) begin
          state_d = ST_STRB_LO;
          if (k_q != LAST_K) nib_d = strobe_nibble(snap_q, k_q + 5'd1);
        end
      end
      ST_STRB_LO: begin
        if (phase_done) begin
          if (k_q == LAST_K) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_STRB_HI;
            k_d     = k_q + 5'd1;
          end
        end
      end
      ST_HOLD: begin
        if (release_req) state_d = ST_RELEASE;
`ifdef ADEX_TX_AUTO_RELEASE_EN
        else if (hold_cnt == 16'(AUTO_RELEASE_CYCLES - 1)) state_d = ST_RELEASE;
`endif
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
    if (state_d == ST_IDLE) nib_d = 4'h0;
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      snap_q        <= '0;
      nib_q         <= '0;
      load_mode_q   <= 1'b0;
      load_enable_q <= 1'b0;
      busy          <= 1'b0;
      holding       <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      snap_q        <= snap_d;
      nib_q         <= nib_d;
      load_mode_q   <= (state_d == ST_ARM) || (state_d == ST_STRB_HI) ||
                       (state_d == ST_STRB_LO) || (state_d == ST_HOLD);
      load_enable_q <= (state_d == ST_STRB_HI);
      busy          <= (state_d != ST_IDLE);
      holding       <= (state_d == ST_HOLD);
      done          <= (state_d == ST_HOLD) && (state_q != ST_HOLD);
    end
  end

  assign bus.load_mode   = load_mode_q;
  assign bus.load_enable = load_enable_q;
  assign bus.nibble      = nib_q;

endmodule

// File: tb/tb_adex_param_loader_tx.sv
// tb/tb_adex_param_loader_tx.sv - directed self-checking bench for adex_param_loader_tx
module tb_adex_param_loader_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] params;
  logic        release_req;
  logic        abort;
  logic        busy;
  logic        holding;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  adex_param_loader_tx_if bus ();

  adex_param_loader_tx dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .params      (params),
    .release_req (release_req),
    .abort       (abort),
    .bus         (bus.master),
    .busy        (busy),
    .holding     (holding),
    .done        (done)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] P_NOM   = 64'h8264_0228_3F4E_90C8;
  localparam logic [71:0] EXP_NOM = 72'h08264022_83F4E90C_8F;
  localparam logic [63:0] P_SEQ   = 64'h0123_4567_89AB_CDEF;
  localparam logic [71:0] EXP_SEQ = 72'h00123456_789ABCDE_FF;
  localparam logic [63:0] P_ALT   = 64'hA5A5_5A5A_C3C3_3C3C;

  logic [3:0] cap_nib [0:31];
  int         cap_cyc [0:31];
  int         cap_cnt, done_cnt, done_cyc, lm_low, stable_err, hi_bad, lo_bad;

  // Sample once per cycle at the falling edge; cycle c is the period before rising edge c
  task automatic capture(input int c0, input int c1);
    logic       le, prev_le;
    logic [3:0] nb, prev_nib;
    int         rise_c, fall_c;
    cap_cnt = 0; done_cnt = 0; done_cyc = -1; lm_low = -1;
    stable_err = 0; hi_bad = 0; lo_bad = 0;
    rise_c = -1; fall_c = -1; prev_le = 1'b0; prev_nib = 4'h0;
    for (int c = c0; c <= c1; c++) begin
      le = bus.load_enable;
      nb = bus.nibble;
      if (le && !prev_le) begin
        if (cap_cnt < 32) begin
          cap_nib[cap_cnt] = nb;
          cap_cyc[cap_cnt] = c;
        end
        cap_cnt++;
        if (fall_c >= 0 && c - fall_c != 2) lo_bad++;
        rise_c = c;
      end
      if (!le && prev_le) begin
        if (c - rise_c != 2) hi_bad++;
        fall_c = c;
      end
      if (le && prev_le && nb != prev_nib) stable_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (!bus.load_mode && lm_low < 0) lm_low = c;
      prev_le  = le;
      prev_nib = nb;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; release_req = 1'b0; abort = 1'b0; params = P_NOM;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.load_mode, bus.load_enable, bus.nibble, busy, holding, done} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000000",
               {bus.load_mode, bus.load_enable, bus.nibble, busy, holding, done});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [71:0] exp_v;
    logic [3:0]  exp_n;
    exp_v  = EXP_NOM;
    params = P_NOM;
    pulse_start();
    n_checks++;
    if (bus.load_mode !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_first_cycle: load_mode=%b busy=%b required 1 1", bus.load_mode, busy);
    end
    capture(1, 85);
    n_checks++;
    if (cap_cnt !== 18) begin
      n_fail++;
      $display("FAIL nom_strobe_count: got %0d required 18", cap_cnt);
    end
    for (int k = 0; k < 18 && k < cap_cnt; k++) begin
      exp_n = exp_v[71 - 4*k -: 4];
      n_checks++;
      if (cap_nib[k] !== exp_n) begin
        n_fail++;
        $display("FAIL nom_nibble[%0d]: got %h required %h", k, cap_nib[k], exp_n);
      end
      n_checks++;
      if (cap_cyc[k] !== 3 + 4*k) begin
        n_fail++;
        $display("FAIL nom_strobe_cycle[%0d]: got %0d required %0d", k, cap_cyc[k], 3 + 4*k);
      end
    end
    n_checks++;
    if (stable_err !== 0) begin
      n_fail++;
      $display("FAIL nom_nibble_stable: %0d changes while high, required 0", stable_err);
    end
    n_checks++;
    if (hi_bad !== 0 || lo_bad !== 0) begin
      n_fail++;
      $display("FAIL nom_phase_len: hi_bad=%0d lo_bad=%0d required 0 0", hi_bad, lo_bad);
    end
    n_checks++;
    if (done_cyc !== 75 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL nom_done: cycle=%0d count=%0d required 75 1", done_cyc, done_cnt);
    end
`ifdef ADEX_TX_AUTO_RELEASE_EN
    n_checks++;
    if (lm_low !== 79 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_release: load_mode low at %0d busy=%b required 79 0", lm_low, busy);
    end
`else
    n_checks++;
    if (lm_low !== -1 || holding !== 1'b1 || bus.load_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_hold: lm_low=%0d holding=%b load_mode=%b required -1 1 1",
               lm_low, holding, bus.load_mode);
    end
`endif
  endtask

  task automatic test_release_and_abort();
    int waited;
    if (!holding) begin
      params = P_NOM;
      pulse_start();
      waited = 0;
      while (!done && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      n_checks++;
      if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL rel_wait_done: timed out after %0d cycles", waited);
      end
    end
    n_checks++;
    if (holding !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_pre_hold: holding=%b required 1", holding);
    end
    release_req = 1'b1;
    @(negedge clk);
    release_req = 1'b0;
    n_checks++;
    if ({bus.load_mode, busy, holding} !== 3'b010) begin
      n_fail++;
      $display("FAIL rel_release_cycle: mode/busy/holding=%b required 010", {bus.load_mode, busy, holding});
    end
    params = P_NOM;
    start  = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.load_mode, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rel_idle: mode/busy=%b required 00", {bus.load_mode, busy});
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({bus.load_mode, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_start: mode/busy=%b required 11", {bus.load_mode, busy});
    end
    repeat (24) @(negedge clk);
    n_checks++;
    if (bus.load_enable !== 1'b0 || bus.nibble !== 4'h2) begin
      n_fail++;
      $display("FAIL abort_pre: le=%b nibble=%h required 0 2", bus.load_enable, bus.nibble);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({bus.load_mode, bus.load_enable, busy, holding} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_next: mode/le/busy/holding=%b required 0000",
               {bus.load_mode, bus.load_enable, busy, holding});
    end
    capture(27, 110);
    n_checks++;
    if (done_cnt !== 0 || cap_cnt !== 0 || lm_low !== 27) begin
      n_fail++;
      $display("FAIL abort_quiet: done=%0d strobes=%0d lm_low=%0d required 0 0 27",
               done_cnt, cap_cnt, lm_low);
    end
  endtask

  task automatic test_ignored();
    logic [71:0] exp_v;
    logic [3:0]  exp_n;
    int          bad;
    exp_v = EXP_SEQ;
    release_req = 1'b1;
    @(negedge clk);
    release_req = 1'b0;
    n_checks++;
    if ({bus.load_mode, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL ign_release_idle: mode/busy=%b required 00", {bus.load_mode, busy});
    end
    params = P_SEQ;
    pulse_start();
    params = P_ALT;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    capture(2, 85);
    n_checks++;
    if (cap_cnt !== 18 || done_cyc !== 75) begin
      n_fail++;
      $display("FAIL ign_start_busy: strobes=%0d done=%0d required 18 75", cap_cnt, done_cyc);
    end
    bad = 0;
    for (int k = 0; k < 18 && k < cap_cnt; k++) begin
      exp_n = exp_v[71 - 4*k -: 4];
      if (cap_nib[k] !== exp_n) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL ign_snapshot: %0d nibbles differ from snapshot, required 0", bad);
    end
    if (holding) begin
      release_req = 1'b1;
      @(negedge clk);
      release_req = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    params = P_NOM;
    pulse_start();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.load_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: le=%b required 1", bus.load_enable);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus.load_mode, bus.load_enable, bus.nibble, busy, holding, done} !== 9'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b required 000000000",
               {bus.load_mode, bus.load_enable, bus.nibble, busy, holding, done});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_release_and_abort();
    test_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
